// File: rtl/not16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : not16_rr_arbiter
//  Description : Round-robin arbiter sharing a single 16-bit bitwise inverter
//                between N_REQ valid/ready requesters. The result is held in
//                one registered stage with its own valid/ready handshake and
//                is tagged with the index of the winning requester.
//                Optional grant statistics are enabled by defining
//                NOT16_RR_ARBITER_STATS_EN (adds clr_stats / grant_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module not16_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [15:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready
`ifdef NOT16_RR_ARBITER_STATS_EN
    ,
    input  logic                  clr_stats,
    output logic [15:0]           grant_count
`endif
);

    localparam int c_DATA_W = 16;

    // Modulo-N_REQ addition used for the circular priority scan and pointer
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    logic [c_DATA_W-1:0] w_ops [N_REQ];
    logic [ID_W-1:0]     w_grant;
    logic                w_any;
    logic                w_accept;
    logic [c_DATA_W-1:0] w_sel;

    logic                r_out_valid;
    logic [c_DATA_W-1:0] r_out_data;
    logic [ID_W-1:0]     r_out_id;
    logic [ID_W-1:0]     r_prio;

    // Split the flat operand bus and decode the one-hot ready vector
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
            assign w_ops[gi]     = req_data[c_DATA_W*gi +: c_DATA_W];
            assign req_ready[gi] = w_accept && (w_grant == ID_W'(gi));
        end
    endgenerate

    // Circular scan from the priority pointer; scanning backwards lets the
    // lowest offset from the pointer be the last (winning) assignment
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(r_prio, k)]) begin
                w_grant = wrap_add(r_prio, k);
                w_any   = 1'b1;
            end
        end
    end

    // rst_n gating keeps every req_ready low for the whole reset assertion
    assign w_accept = rst_n && en && w_any && (!r_out_valid || out_ready);
    assign w_sel    = w_ops[w_grant];

    // Result stage: load on accept (also covers drain+load), else drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_prio      <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ~w_sel;
            r_out_id    <= w_grant;
            r_prio      <= wrap_add(w_grant, 1);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

`ifdef NOT16_RR_ARBITER_STATS_EN
    logic [15:0] r_grant_count;

    // Saturating accept counter; a synchronous clear beats a same-cycle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_count <= '0;
        end else if (clr_stats) begin
            r_grant_count <= '0;
        end else if (w_accept && (r_grant_count != 16'hFFFF)) begin
            r_grant_count <= r_grant_count + 16'd1;
        end
    end

    assign grant_count = r_grant_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_not16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_not16_rr_arbiter
//  Description : Scoreboard bench for not16_rr_arbiter. A driver issues
//                directed and random stimulus and pushes expected results
//                from a behavioural model; a monitor pops and compares on
//                every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_not16_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        logic [15:0]   data;
        logic [IW-1:0] id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [15:0]     out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready = 1'b0;
`ifdef NOT16_RR_ARBITER_STATS_EN
    logic            clr_stats = 1'b0;
    logic [15:0]     grant_count;
`endif

    not16_rr_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
`ifdef NOT16_RR_ARBITER_STATS_EN
        ,
        .clr_stats   (clr_stats),
        .grant_count (grant_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [N-1:0] v = '0;
    logic [15:0] d [N];
    int          prio = 0;
    logic        m_valid = 1'b0;
    logic        last_acc = 1'b0;
    int          last_g = 0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs at negedge, check combinational outputs,
    // advance the reference model, then move to the next negedge
    task automatic step();
        int          g;
        logic        acc;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = d[i];
        req_valid = v;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (prio + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        acc = en && (g >= 0) && (!m_valid || out_ready);
        er = '0;
        if (acc) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_valid));
`ifdef NOT16_RR_ARBITER_STATS_EN
        check("grant_count", 32'(grant_count), 32'(m_cnt));
        if (clr_stats) m_cnt = 0;
        else if (acc && m_cnt < 65535) m_cnt++;
`endif
        if (acc) begin
            q.push_back('{data: ~d[g], id: g[IW-1:0]});
            prio    = (g + 1) % N;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        last_acc = acc;
        last_g   = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every output handshake retires the oldest expected result
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got unexpected result %0h id %0d expected none", out_data, out_id);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.data));
                    check("sb_id", 32'(out_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        logic [15:0]   hd;
        logic [IW-1:0] hid;
        for (int i = 0; i < N; i++) d[i] = '0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation with all requesting
        en = 1'b1;
        out_ready = 1'b1;
        v = '1;
        for (int i = 0; i < N; i++) d[i] = 16'h00FF << i;
        step();
        check("rot0_id", 32'(out_id), 32'd0);
        check("rot0_data", 32'(out_data), 32'hFF00);
        step();
        check("rot1_id", 32'(out_id), 32'd1);
        check("rot1_data", 32'(out_data), 32'hFE01);
        step();
        check("rot2_id", 32'(out_id), 32'd2);
        step();
        check("rot3_id", 32'(out_id), 32'd3);
        step();
        check("rot4_id", 32'(out_id), 32'd0);

        // Backpressure: result holds, next grant continues rotation
        hd  = out_data;
        hid = out_id;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_data", 32'(out_data), 32'(hd));
            check("bp_hold_id", 32'(out_id), 32'(hid));
        end
        out_ready = 1'b1;
        step();
        check("bp_next_id", 32'(out_id), 32'd1);

        // Sparse / wrap
        v = 4'b0100;
        step();
        v = 4'b0010;
        d[1] = 16'h0000;
        step();
        check("sparse_id", 32'(out_id), 32'd1);
        check("sparse_data", 32'(out_data), 32'hFFFF);
        v = 4'b1001;
        step();
        check("wrap_first", 32'(out_id), 32'd3);
        v = 4'b0001;
        step();
        check("wrap_second", 32'(out_id), 32'd0);

        // Enable off: no grants, pending result drains
        v = '1;
        out_ready = 1'b0;
        step();
        en = 1'b0;
        out_ready = 1'b1;
        step();
        check("en0_drained", 32'(out_valid), 32'd0);
        step();
        en = 1'b1;
        step();
        check("en1_resume_id", 32'(out_id), 32'd1);

        // Asynchronous reset with a loaded result
        v = '0;
        step();
        step();
        v = 4'b0001;
        d[0] = 16'hEDCB;
        out_ready = 1'b0;
        step();
        check("pre_rst_data", 32'(out_data), 32'h1234);
        v = '1;
        req_valid = v;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_id", 32'(out_id), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        q.delete();
        prio = 0;
        m_valid = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst_grant", 32'(out_id), 32'd0);

        // Randomized traffic honouring the hold-until-accepted rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || (last_acc && last_g == i)) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    d[i] = 16'($urandom);
                end
            end
            en = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef NOT16_RR_ARBITER_STATS_EN
            clr_stats = ($urandom_range(0, 49) == 0);
`endif
            step();
        end

        // Drain remaining result
        v = '0;
        en = 1'b0;
        out_ready = 1'b1;
`ifdef NOT16_RR_ARBITER_STATS_EN
        clr_stats = 1'b0;
`endif
        step();
        step();
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/not16_rr_arbiter.md
Name: not16_rr_arbiter

Overview:
- Shares one 16-bit inverter datapath (out = ~in, bitwise, all 16 bits) between N_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Single registered result stage with its own valid/ready handshake toward the consumer, tagged with the winning requester index.
- Sits between multiple 16-bit producers and a single downstream consumer in the gates/ALU area.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(N_REQ), width of the requester index; minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; when 0, no new grants are issued.
- req_valid  input  N_REQ  per-requester valid.
- req_data  input  16*N_REQ  requester i's operand on bits [16*i+15:16*i].
- req_ready  output  N_REQ  per-requester accept; at most one bit set.
- out_valid  output  1  result register holds a valid result.
- out_data  output  16  inverted operand.
- out_id  output  ID_W  index of the requester that produced out_data.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is asynchronous, active-low, on assertion.
  - out_valid=0, out_data=16'h0000, out_id=0, priority pointer prio=0.
  - Any in-flight result is discarded.
  - req_ready=0 while rst_n=0.
- Grant selection (combinational):
  - grant is the first index i with req_valid[i]=1, scanning prio, prio+1, ... N_REQ-1, 0, ... prio-1 (modulo wrap).
  - any_req = |req_valid.
- Accept condition:
  - accept = en && any_req && (!out_valid || out_ready).
  - req_ready[grant] = accept; all other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid, en and out_ready.
  - Requesters must hold req_valid and req_data stable until accepted.
- On a clock edge with accept=1:
  - out_data <= ~req_data[grant].
  - out_id <= grant.
  - out_valid <= 1.
  - prio <= (grant+1) mod N_REQ, wrapping N_REQ-1 to 0.
- On a clock edge with out_valid && out_ready && !accept:
  - out_valid <= 0.
  - out_data and out_id hold their values.
- Simultaneous drain and accept (out_valid && out_ready && accept):
  - The result register is overwritten with the new result.
  - out_valid stays 1.
  - Sustained throughput is 1 result per cycle.
- Backpressure (out_valid && !out_ready):
  - No accept, so req_ready is all zeros.
  - out_data, out_id and prio hold.
- Latency: an operand accepted at edge k appears on out_data after edge k, i.e. 1 cycle.
- en=0 blocks new grants only. A pending result still drains normally.
- The pointer advances only on accept, never on idle cycles.
- With a single active requester, every cycle grants that requester regardless of prio.
- No combinational path from req_data to out_data; out_data is always registered.

Optional Feature:
- Macro: NOT16_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_count, 16 bits.
  - Counts accepts and increments by 1 on each accept edge.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
  - Adds input clr_stats, 1 bit: synchronously clears grant_count to 0. Clear wins over a same-cycle increment.
- Undefined: neither port exists, and arbitration/datapath behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-run with out_valid=1 and out_data=16'h1234 -> out_valid=0, out_data=16'h0000, out_id=0 and req_ready=0 immediately, without waiting for a clock edge. After release, the first grant goes to requester 0 when all request.
- Rotation: N_REQ=4, all req_valid=1, data i = 16'h00FF<<i, out_ready=1.
  - out_id sequence is 0,1,2,3,0,...
  - First out_data=16'hFF00, second out_data=16'hFE01.
  - One result per cycle.
- Backpressure: out_ready=0 for 3 cycles after a result is loaded -> out_data/out_id hold, req_ready=4'b0000. After out_ready=1, the next grant goes to the next index in rotation.
- Sparse/wrap: prio=3 with only req_valid[1]=1 and data=16'h0000 -> grant 1, out_data=16'hFFFF, prio becomes 2. Then req_valid[3] and req_valid[0] both valid -> grant 3 first, then 0.
- Enable/idle: en=0 with requests pending -> no req_ready, and an existing result drains (out_valid falls after out_ready). en=1 -> grants resume from the unchanged prio.
- Stats (NOT16_RR_ARBITER_STATS_EN defined): 10 accepts -> grant_count=10. Asserting clr_stats during an accept -> grant_count=0 on the next cycle.
